sha256_multiblock_core: RTL and testbench

//  Parametrised SHA-256 engine: hashes messages of any length as a chain of pre-padded 512-bit blocks.

---
 rtl/sha256_pkg.sv | 53 +++++
 rtl/sha256_multiblock_core_if.sv | 25 ++
 rtl/sha256_round.sv | 16 +
 rtl/sha256_multiblock_core.sv | 139 +++++++++++++
 tb/tb_sha256_multiblock_core.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/sha256_pkg.sv
// SHA-256 constants, FSM state type and the round/schedule helper functions.
package sha256_pkg;

  typedef enum logic [1:0] {eIdle, eBusy, eNext, eDone} state_e;

  // H0 in the top word, matching digest_o ordering
  localparam logic [255:0] IV =
    256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic logic [31:0] ch(logic [31:0] e, logic [31:0] f, logic [31:0] g);
    return (e & f) ^ (~e & g);
  endfunction

  function automatic logic [31:0] maj(logic [31:0] a, logic [31:0] b, logic [31:0] c);
    return (a & b) ^ (a & c) ^ (b & c);
  endfunction

  function automatic logic [31:0] big_sigma0(logic [31:0] x);
    return {x[1:0], x[31:2]} ^ {x[12:0], x[31:13]} ^ {x[21:0], x[31:22]};
  endfunction

  function automatic logic [31:0] big_sigma1(logic [31:0] x);
    return {x[5:0], x[31:6]} ^ {x[10:0], x[31:11]} ^ {x[24:0], x[31:25]};
  endfunction

  function automatic logic [31:0] small_sigma0(logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction

  function automatic logic [31:0] small_sigma1(logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction

endpackage

// File: rtl/sha256_multiblock_core_if.sv
// Block-in / digest-out handshake bundle for sha256_multiblock_core.
// SHA256_MIDSTATE_EN adds midstate_i / use_mid_i.
interface sha256_multiblock_core_if;
  logic         v_i;
  logic         ready_o;
  logic [511:0] msg_i;
  logic         last_i;
  logic         v_o;
  logic         yumi_i;
  logic [255:0] digest_o;
`ifdef SHA256_MIDSTATE_EN
  logic [255:0] midstate_i;
  logic         use_mid_i;

  modport master (output v_i, msg_i, last_i, yumi_i, midstate_i, use_mid_i,
                  input  ready_o, v_o, digest_o);
  modport slave  (input  v_i, msg_i, last_i, yumi_i, midstate_i, use_mid_i,
                  output ready_o, v_o, digest_o);
`else
  modport master (output v_i, msg_i, last_i, yumi_i,
                  input  ready_o, v_o, digest_o);
  modport slave  (input  v_i, msg_i, last_i, yumi_i,
                  output ready_o, v_o, digest_o);
`endif
endinterface

// File: rtl/sha256_round.sv
// One combinational SHA-256 compression round; state packed as {a,b,c,d,e,f,g,h}.
module sha256_round
  import sha256_pkg::*;
(
  input  logic [255:0] cur,
  input  logic [31:0]  k,
  input  logic [31:0]  w,
  output logic [255:0] nxt
);
  logic [31:0] a, b, c, d, e, f, g, h, t1, t2;

  assign {a, b, c, d, e, f, g, h} = cur;
  assign t1  = h + big_sigma1(e) + ch(e, f, g) + k + w;
  assign t2  = big_sigma0(a) + maj(a, b, c);
  assign nxt = {t1 + t2, a, b, c, d + t1, e, f, g};
endmodule

// File: rtl/sha256_multiblock_core.sv
// Multi-block SHA-256 engine, ROUNDS_PER_CYCLE rounds per clock.
// SHA256_MIDSTATE_EN enables starting the first block from an external midstate.
module sha256_multiblock_core
  import sha256_pkg::*;
#(
  parameter int unsigned ROUNDS_PER_CYCLE = 1,
  parameter string       core_id          = "inv"
) (
  input logic                     clk_i,
  input logic                     reset_n_i,
  input logic                     en_i,
  sha256_multiblock_core_if.slave bus
);
  localparam int unsigned NumSteps = 64 / ROUNDS_PER_CYCLE;
  localparam logic [5:0]  LastCtr  = 6'(NumSteps - 1);

  if (!(ROUNDS_PER_CYCLE == 1 || ROUNDS_PER_CYCLE == 2 ||
        ROUNDS_PER_CYCLE == 4 || ROUNDS_PER_CYCLE == 8)) begin : g_bad_rounds
    $error("sha256_multiblock_core %s: ROUNDS_PER_CYCLE=%0d not in {1,2,4,8}",
           core_id, ROUNDS_PER_CYCLE);
  end

  state_e              state_q, state_d;
  logic [5:0]          ctr_q, ctr_d;
  logic                last_q, last_d;
  logic [255:0]        h_q, h_d, work_q, work_d, digest_q, digest_d;
  logic [15:0][31:0]   win_q, win_d, msg_win;
  logic [255:0]        init_state, h_sum;
  logic                accept;

  // win[0] always holds W_t for the current round; the window slides one word per round
  logic [15:0][31:0]   win_chain [ROUNDS_PER_CYCLE+1];
  logic [255:0]        st_chain  [ROUNDS_PER_CYCLE+1];

  assign win_chain[0] = win_q;
  assign st_chain[0]  = work_q;

  for (genvar j = 0; j < ROUNDS_PER_CYCLE; j++) begin : g_rounds
    logic [5:0]  rnd_idx;
    logic [31:0] w_new;
    assign rnd_idx = 6'(int'(ctr_q) * ROUNDS_PER_CYCLE + j);
    assign w_new   = small_sigma1(win_chain[j][14]) + win_chain[j][9] +
                     small_sigma0(win_chain[j][1]) + win_chain[j][0];
    assign win_chain[j+1] = {w_new, win_chain[j][15:1]};
    sha256_round u_round (
      .cur (st_chain[j]),
      .k   (K[rnd_idx]),
      .w   (win_chain[j][0]),
      .nxt (st_chain[j+1])
    );
  end

  always_comb begin
    for (int i = 0; i < 16; i++) msg_win[i] = bus.msg_i[511 - 32*i -: 32];
    for (int i = 0; i < 8; i++) begin
      h_sum[32*i +: 32] = h_q[32*i +: 32] + st_chain[ROUNDS_PER_CYCLE][32*i +: 32];
    end
  end

`ifdef SHA256_MIDSTATE_EN
  assign init_state = bus.use_mid_i ? bus.midstate_i : IV;
`else
  assign init_state = IV;
`endif

  assign bus.ready_o  = (state_q == eIdle) || (state_q == eNext);
  assign bus.v_o      = (state_q == eDone);
  assign bus.digest_o = digest_q;
  assign accept       = bus.v_i & bus.ready_o & en_i;

  always_comb begin
    state_d  = state_q;
    ctr_d    = ctr_q;
    last_d   = last_q;
    h_d      = h_q;
    work_d   = work_q;
    win_d    = win_q;
    digest_d = digest_q;
    if (en_i) begin
      unique case (state_q)
        eIdle: if (accept) begin
          win_d   = msg_win;
          h_d     = init_state;
          work_d  = init_state;
          ctr_d   = '0;
          last_d  = bus.last_i;
          state_d = eBusy;
        end
        eBusy: begin
          work_d = st_chain[ROUNDS_PER_CYCLE];
          win_d  = win_chain[ROUNDS_PER_CYCLE];
          ctr_d  = ctr_q + 6'd1;
          if (ctr_q == LastCtr) begin
            h_d = h_sum;
            if (last_q) begin
              digest_d = h_sum;
              state_d  = eDone;
            end else begin
              state_d  = eNext;
            end
          end
        end
        eNext: if (accept) begin
          win_d   = msg_win;
          work_d  = h_q;
          ctr_d   = '0;
          last_d  = bus.last_i;
          state_d = eBusy;
        end
        eDone: if (bus.yumi_i) begin
          h_d     = IV;
          state_d = eIdle;
        end
        default: state_d = eIdle;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q  <= eIdle;
      ctr_q    <= '0;
      last_q   <= 1'b0;
      h_q      <= IV;
      work_q   <= '0;
      win_q    <= '0;
      digest_q <= '0;
    end else begin
      state_q  <= state_d;
      ctr_q    <= ctr_d;
      last_q   <= last_d;
      h_q      <= h_d;
      work_q   <= work_d;
      win_q    <= win_d;
      digest_q <= digest_d;
    end
  end

endmodule

// File: tb/tb_sha256_multiblock_core.sv
// Scoreboard bench for sha256_multiblock_core: known-answer vectors, handshake and control corners.
module tb_sha256_multiblock_core;
  parameter int unsigned R = 1;
  localparam int unsigned Lat = 64 / R + 1;

  localparam logic [511:0] AbcMsg = {32'h61626380, 448'h0, 32'h00000018};
  localparam logic [255:0] AbcDig =
    256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
  localparam logic [511:0] EmptyMsg = {32'h80000000, 480'h0};
  localparam logic [255:0] EmptyDig =
    256'he3b0c442_98fc1c14_9afbf4c8_996fb924_27ae41e4_649b934c_a495991b_7852b855;
  localparam logic [511:0] TwoB1 = {
    32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
    32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
    32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
    32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
  localparam logic [511:0] TwoB2 = {480'h0, 32'h000001c0};
  localparam logic [255:0] TwoDig =
    256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;
  localparam logic [255:0] TwoMid =
    256'h85e655d6_417a1795_3363376a_624cde5c_76e09589_cac5f811_cc4b32c1_f20e533a;

  logic clk = 1'b0;
  logic rst_n;
  logic en;
  always #5 clk = ~clk;

  sha256_multiblock_core_if bus ();

  sha256_multiblock_core #(.ROUNDS_PER_CYCLE(R)) dut (
    .clk_i     (clk),
    .reset_n_i (rst_n),
    .en_i      (en),
    .bus       (bus)
  );

  int n_checks = 0;
  int n_bad    = 0;
  logic [255:0] exp_q [$];

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_block(input logic [511:0] m, input logic last, input logic push,
                            input logic [255:0] exp);
    int cnt = 0;
    bus.msg_i  = m;
    bus.last_i = last;
    bus.v_i    = 1'b1;
    while (!(bus.ready_o && en) && cnt < 500) begin
      tick();
      cnt++;
    end
    check("accept_in_time", 256'(cnt < 500), 256'd1);
    tick();
    bus.v_i    = 1'b0;
    bus.last_i = 1'b0;
    if (push) exp_q.push_back(exp);
  endtask

  // Edges from the accepting edge (counted as 1) until v_o is seen high
  task automatic wait_vo(output int lat);
    lat = 1;
    while (!bus.v_o && lat < 1000) begin
      tick();
      lat++;
    end
  endtask

  task automatic take_digest(input string tag);
    logic [255:0] e;
    check({tag, "_vo"}, 256'(bus.v_o), 256'd1);
    if (exp_q.size() == 0) begin
      check({tag, "_sb_empty"}, 256'd0, 256'd1);
    end else begin
      e = exp_q.pop_front();
      check(tag, bus.digest_o, e);
    end
    bus.yumi_i = 1'b1;
    tick();
    bus.yumi_i = 1'b0;
    check({tag, "_vo_drop"}, 256'(bus.v_o), 256'd0);
    check({tag, "_ready"}, 256'(bus.ready_o), 256'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    int lat;
    int cnt;
    logic saw;
    logic [255:0] e;
    rst_n = 1'b0;
    en    = 1'b1;
    bus.v_i = 1'b0; bus.msg_i = '0; bus.last_i = 1'b0; bus.yumi_i = 1'b0;
`ifdef SHA256_MIDSTATE_EN
    bus.midstate_i = '0;
    bus.use_mid_i  = 1'b0;
`endif
    tick(); tick();
    check("rst_digest", bus.digest_o, 256'd0);
    check("rst_vo", 256'(bus.v_o), 256'd0);
    check("rst_ready", 256'(bus.ready_o), 256'd1);
    rst_n = 1'b1;
    tick();

    send_block(AbcMsg, 1'b1, 1'b1, AbcDig);
    wait_vo(lat);
    check("abc_latency", 256'(lat), 256'(Lat));
    take_digest("abc");

    send_block(EmptyMsg, 1'b1, 1'b1, EmptyDig);
    wait_vo(lat);
    take_digest("empty");

    send_block(TwoB1, 1'b0, 1'b0, '0);
    cnt = 0;
    while (!bus.ready_o && cnt < 500) begin tick(); cnt++; end
    check("two_enext", 256'(bus.ready_o), 256'd1);
    for (int i = 0; i < 20; i++) begin
      check("gap_ready", 256'(bus.ready_o), 256'd1);
      check("gap_vo", 256'(bus.v_o), 256'd0);
      tick();
    end
    send_block(TwoB2, 1'b1, 1'b1, TwoDig);
    wait_vo(lat);
    take_digest("two_block");

    // Back-pressure: digest held while a stray block is offered
    send_block(AbcMsg, 1'b1, 1'b1, AbcDig);
    wait_vo(lat);
    e = exp_q[0];
    bus.v_i = 1'b1; bus.msg_i = EmptyMsg; bus.last_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      check("bp_digest", bus.digest_o, e);
      check("bp_vo", 256'(bus.v_o), 256'd1);
      check("bp_ready", 256'(bus.ready_o), 256'd0);
      tick();
    end
    bus.v_i = 1'b0; bus.last_i = 1'b0;
    take_digest("bp_abc");
    send_block(AbcMsg, 1'b1, 1'b1, AbcDig);
    wait_vo(lat);
    take_digest("post_bp_abc");

    // Enable freeze mid-block, then in eDone
    send_block(AbcMsg, 1'b1, 1'b1, AbcDig);
    repeat (30 / R) tick();
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("freeze_vo", 256'(bus.v_o), 256'd0);
      check("freeze_ready", 256'(bus.ready_o), 256'd0);
      tick();
    end
    en = 1'b1;
    wait_vo(lat);
    check("freeze_latency", 256'(lat + 30 / R + 5), 256'(Lat + 5));
    en = 1'b0;
    bus.yumi_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("en_low_yumi_vo", 256'(bus.v_o), 256'd1);
    end
    bus.yumi_i = 1'b0;
    en = 1'b1;
    take_digest("freeze_abc");

    // Reset mid-block aborts without a digest
    send_block(AbcMsg, 1'b1, 1'b0, '0);
    repeat (40 / R) tick();
    rst_n = 1'b0;
    #1;
    check("abort_vo", 256'(bus.v_o), 256'd0);
    check("abort_ready", 256'(bus.ready_o), 256'd1);
    check("abort_digest", bus.digest_o, 256'd0);
    tick();
    rst_n = 1'b1;
    saw = 1'b0;
    for (int i = 0; i < 80; i++) begin
      saw |= bus.v_o;
      tick();
    end
    check("abort_no_vo", 256'(saw), 256'd0);
    send_block(AbcMsg, 1'b1, 1'b1, AbcDig);
    wait_vo(lat);
    take_digest("post_abort_abc");

`ifdef SHA256_MIDSTATE_EN
    bus.midstate_i = TwoMid;
    bus.use_mid_i  = 1'b1;
    send_block(TwoB2, 1'b1, 1'b1, TwoDig);
    bus.use_mid_i  = 1'b0;
    wait_vo(lat);
    take_digest("midstate");
`endif

    check("sb_drained", 256'(exp_q.size()), 256'd0);
    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
